// File: rtl/instruction_decode_stage_if.sv
// Bundle of the fetch-side, execute-side and writeback signals around the LEGv8 decode stage.
// master = the surrounding pipeline / bench, slave = the decode stage itself.
interface instruction_decode_stage_if #(
  parameter int XLEN = 64
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Fetch->decode uses if_valid/id_ready, decode->execute uses ex_valid/ex_ready.
  // The sender holds its payload stable until the transfer; ready may depend on valid.
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  logic            pc_src;
  logic [XLEN-1:0] branch_address;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_rd1;
  logic [XLEN-1:0] ex_rd2;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic [3:0]      ex_alu_op;
  logic            ex_alu_src;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_halt;
  logic            ex_illegal;

  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (
    output if_valid, if_instr, if_pc, ex_ready, wb_en, wb_addr, wb_data,
    input  id_ready, pc_src, branch_address, ex_valid, ex_rd1, ex_rd2, ex_imm, ex_rd,
           ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt, ex_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready, wb_en, wb_addr, wb_data,
    output id_ready, pc_src, branch_address, ex_valid, ex_rd1, ex_rd2, ex_imm, ex_rd,
           ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt, ex_illegal
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// LEGv8 decode stage: register file with write bypass, control/immediate generation,
// local resolution of B/CBZ/CBNZ, and a registered ID/EX stage towards execute.
module instruction_decode_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input logic                        clk,
  input logic                        reset,
  instruction_decode_stage_if.slave  bus
);

  localparam logic [4:0] XZR     = 5'd31;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ORR = 4'b0001;

  typedef enum logic [3:0] {
    OP_ILLEGAL, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
    OP_LDUR, OP_STUR, OP_CBZ, OP_CBNZ, OP_B, OP_HALT
  } op_e;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            halt;
    logic            illegal;
  } idex_t;

  logic [XLEN-1:0] r_regs [0:NREGS-1];
  logic            r_halted;
  logic            r_pc_src;
  logic [XLEN-1:0] r_branch_address;
  logic            r_ex_valid;
  idex_t           r_idex;

  op_e             w_op;
  logic [4:0]      w_rn_idx;
  logic [4:0]      w_rb_idx;
  logic [XLEN-1:0] w_rn_val;
  logic [XLEN-1:0] w_rb_val;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_d;
  logic [XLEN-1:0] w_imm_cb;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_branch_imm;
  logic            w_forward;
  logic            w_taken;
  idex_t           w_idex;
  logic            w_id_ready;
  logic            w_accept;
  logic            w_live;
  logic            w_load_ex;
  logic            w_redirect;

  // Opcode classification on the top 11 bits
  always_comb begin
    w_op = OP_ILLEGAL;
    casez (bus.if_instr[31:21])
      11'b10001011000: w_op = OP_ADD;
      11'b11001011000: w_op = OP_SUB;
      11'b10001010000: w_op = OP_AND;
      11'b10101010000: w_op = OP_ORR;
      11'b1001000100?: w_op = OP_ADDI;
      11'b1101000100?: w_op = OP_SUBI;
      11'b11111000010: w_op = OP_LDUR;
      11'b11111000000: w_op = OP_STUR;
      11'b10110100???: w_op = OP_CBZ;
      11'b10110101???: w_op = OP_CBNZ;
      11'b000101?????: w_op = OP_B;
      11'b11111111111: w_op = OP_HALT;
      default:         w_op = OP_ILLEGAL;
    endcase
  end

  // Second read port: Rm for R-type, Rt for stores and compare-branches
  assign w_rn_idx = bus.if_instr[9:5];
  assign w_rb_idx = (w_op == OP_ADD || w_op == OP_SUB || w_op == OP_AND || w_op == OP_ORR)
                    ? bus.if_instr[20:16] : bus.if_instr[4:0];

  always_comb begin
    w_rn_val = '0;
    w_rb_val = '0;
    if (w_rn_idx != XZR) begin
      w_rn_val = (bus.wb_en && bus.wb_addr == w_rn_idx) ? bus.wb_data : r_regs[w_rn_idx];
    end
    if (w_rb_idx != XZR) begin
      w_rb_val = (bus.wb_en && bus.wb_addr == w_rb_idx) ? bus.wb_data : r_regs[w_rb_idx];
    end
  end

  assign w_imm_i  = {{(XLEN-12){1'b0}}, bus.if_instr[21:10]};
  assign w_imm_d  = {{(XLEN-9){bus.if_instr[20]}}, bus.if_instr[20:12]};
  assign w_imm_cb = {{(XLEN-21){bus.if_instr[23]}}, bus.if_instr[23:5], 2'b00};
  assign w_imm_b  = {{(XLEN-28){bus.if_instr[25]}}, bus.if_instr[25:0], 2'b00};

  // Control generation; anything not listed leaves the ID/EX fields at zero
  always_comb begin
    w_idex       = '0;
    w_forward    = 1'b1;
    w_taken      = 1'b0;
    w_branch_imm = '0;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        w_idex.rd1       = w_rn_val;
        w_idex.rd2       = w_rb_val;
        w_idex.rd        = bus.if_instr[4:0];
        w_idex.reg_write = 1'b1;
        w_idex.alu_op    = (w_op == OP_ADD) ? ALU_ADD :
                           (w_op == OP_SUB) ? ALU_SUB :
                           (w_op == OP_AND) ? ALU_AND : ALU_ORR;
      end
      OP_ADDI, OP_SUBI: begin
        w_idex.rd1       = w_rn_val;
        w_idex.imm       = w_imm_i;
        w_idex.rd        = bus.if_instr[4:0];
        w_idex.alu_src   = 1'b1;
        w_idex.reg_write = 1'b1;
        w_idex.alu_op    = (w_op == OP_ADDI) ? ALU_ADD : ALU_SUB;
      end
      OP_LDUR: begin
        w_idex.rd1       = w_rn_val;
        w_idex.imm       = w_imm_d;
        w_idex.rd        = bus.if_instr[4:0];
        w_idex.alu_op    = ALU_ADD;
        w_idex.alu_src   = 1'b1;
        w_idex.reg_write = 1'b1;
        w_idex.mem_read  = 1'b1;
      end
      OP_STUR: begin
        w_idex.rd1       = w_rn_val;
        w_idex.rd2       = w_rb_val;
        w_idex.imm       = w_imm_d;
        w_idex.rd        = bus.if_instr[4:0];
        w_idex.alu_op    = ALU_ADD;
        w_idex.alu_src   = 1'b1;
        w_idex.mem_write = 1'b1;
      end
      OP_CBZ, OP_CBNZ: begin
        w_forward    = 1'b0;
        w_branch_imm = w_imm_cb;
        w_taken      = (w_op == OP_CBZ) ? (w_rb_val == '0) : (w_rb_val != '0);
      end
      OP_B: begin
        w_forward    = 1'b0;
        w_branch_imm = w_imm_b;
        w_taken      = 1'b1;
      end
      OP_HALT:    w_idex.halt    = 1'b1;
      default:    w_idex.illegal = 1'b1;
    endcase
  end

  // The slot right after a redirect always holds a wrong-path instruction, so it is drained
  assign w_id_ready = (!r_halted && (!r_ex_valid || bus.ex_ready)) || r_pc_src;
  assign w_accept   = bus.if_valid && w_id_ready;
  assign w_live     = w_accept && !r_pc_src;
  assign w_load_ex  = w_live && w_forward;
  assign w_redirect = w_live && w_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != XZR) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_halted         <= 1'b0;
      r_pc_src         <= 1'b0;
      r_branch_address <= '0;
      r_ex_valid       <= 1'b0;
      r_idex           <= '0;
    end else begin
      r_pc_src <= w_redirect;
      if (w_redirect) begin
        r_branch_address <= bus.if_pc + w_branch_imm;
      end
      if (w_live && w_op == OP_HALT) begin
        r_halted <= 1'b1;
      end
      if (w_load_ex) begin
        r_ex_valid <= 1'b1;
        r_idex     <= w_idex;
      end else if (bus.ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign bus.id_ready       = w_id_ready;
  assign bus.pc_src         = r_pc_src;
  assign bus.branch_address = r_branch_address;
  assign bus.ex_valid       = r_ex_valid;
  assign bus.ex_rd1         = r_idex.rd1;
  assign bus.ex_rd2         = r_idex.rd2;
  assign bus.ex_imm         = r_idex.imm;
  assign bus.ex_rd          = r_idex.rd;
  assign bus.ex_alu_op      = r_idex.alu_op;
  assign bus.ex_alu_src     = r_idex.alu_src;
  assign bus.ex_reg_write   = r_idex.reg_write;
  assign bus.ex_mem_read    = r_idex.mem_read;
  assign bus.ex_mem_write   = r_idex.mem_write;
  assign bus.ex_halt        = r_idex.halt;
  assign bus.ex_illegal     = r_idex.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: expected ID/EX payloads and redirect targets
// are queued at issue time and popped by independent monitors.
module tb_instruction_decode_stage;
  localparam int PW = 207;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_decode_stage_if tb_if ();

  instruction_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tb_if)
  );

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [63:0]   br_q[$];

  wire [PW-1:0] w_act = {tb_if.ex_rd1, tb_if.ex_rd2, tb_if.ex_imm, tb_if.ex_rd, tb_if.ex_alu_op,
                         tb_if.ex_alu_src, tb_if.ex_reg_write, tb_if.ex_mem_read,
                         tb_if.ex_mem_write, tb_if.ex_halt, tb_if.ex_illegal};

  function automatic logic [PW-1:0] pk(input logic [63:0] rd1, input logic [63:0] rd2,
                                       input logic [63:0] imm, input logic [4:0] rd,
                                       input logic [3:0] op, input logic src, input logic rw,
                                       input logic mr, input logic mw, input logic hlt,
                                       input logic ill);
    return {rd1, rd2, imm, rd, op, src, rw, mr, mw, hlt, ill};
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- clock / reset and driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [63:0] d);
    tb_if.wb_en   = 1'b1;
    tb_if.wb_addr = a;
    tb_if.wb_data = d;
    tick();
    tb_if.wb_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins, input logic [63:0] pc);
    int n;
    n = 0;
    tb_if.if_valid = 1'b1;
    tb_if.if_instr = ins;
    tb_if.if_pc    = pc;
    @(negedge clk);
    while (!tb_if.id_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: id_ready stayed 0 for instr %h, required 1", ins);
    end
    tick();
    tb_if.if_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!reset && tb_if.ex_valid && tb_if.ex_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ex_unexpected: got payload %h, required no ex_valid", w_act);
      end else begin
        chk("ex_payload", w_act, exp_q.pop_front());
      end
    end
    if (!reset && tb_if.pc_src) begin
      if (br_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pc_src_unexpected: got target %h, required pc_src=0", tb_if.branch_address);
      end else begin
        chk("branch_address", PW'(tb_if.branch_address), PW'(br_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  logic [PW-1:0] ldur_exp;

  initial begin
    reset          = 1'b1;
    tb_if.if_valid = 1'b0;
    tb_if.if_instr = '0;
    tb_if.if_pc    = '0;
    tb_if.ex_ready = 1'b1;
    tb_if.wb_en    = 1'b0;
    tb_if.wb_addr  = '0;
    tb_if.wb_data  = '0;
    do_reset();

    @(negedge clk);
    chk("reset_id_ready", PW'(tb_if.id_ready), PW'(1));
    chk("reset_pc_src", PW'(tb_if.pc_src), PW'(0));
    chk("reset_branch_address", PW'(tb_if.branch_address), PW'(0));
    chk("reset_ex_valid", PW'(tb_if.ex_valid), PW'(0));
    chk("reset_payload", w_act, '0);
    tick();

    // ADD X3,X1,X2
    wb(5'd1, 64'd5);
    wb(5'd2, 64'd7);
    exp_q.push_back(pk(64'd5, 64'd7, 64'd0, 5'd3, 4'b0010, 0, 1, 0, 0, 0, 0));
    send(32'h8B020023, 64'h0);

    // ADDI X4,XZR,#0xFFF while writing back to X31
    tb_if.wb_en = 1'b1; tb_if.wb_addr = 5'd31; tb_if.wb_data = 64'hDEAD;
    exp_q.push_back(pk(64'd0, 64'd0, 64'hFFF, 5'd4, 4'b0010, 1, 1, 0, 0, 0, 0));
    send(32'h913FFFE4, 64'h4);
    tb_if.wb_en = 1'b0;
    // ADD X6,XZR,XZR: X31 still reads 0
    exp_q.push_back(pk(64'd0, 64'd0, 64'd0, 5'd6, 4'b0010, 0, 1, 0, 0, 0, 0));
    send(32'h8B1F03E6, 64'h8);

    // B -2 at 0x40, then a wrong-path ADD in the shadow slot
    br_q.push_back(64'h38);
    send(32'h17FFFFFE, 64'h40);
    send(32'h8B020023, 64'h44);
    @(negedge clk);
    chk("flush_ex_valid", PW'(tb_if.ex_valid), PW'(0));
    chk("pc_src_one_cycle", PW'(tb_if.pc_src), PW'(0));
    tick();

    // CBZ X5 taken, then X5=9 not taken, then CBNZ X5 taken
    br_q.push_back(64'h20);
    send(32'hB4000085, 64'h10);
    wb(5'd5, 64'd9);
    send(32'hB4000085, 64'h10);
    @(negedge clk);
    chk("cbz_not_taken", PW'(tb_if.pc_src), PW'(0));
    tick();
    br_q.push_back(64'h110);
    send(32'hB5000085, 64'h100);
    tick();

    // ADD X7,X1,X2 with a same-cycle writeback of X1
    tb_if.wb_en = 1'b1; tb_if.wb_addr = 5'd1; tb_if.wb_data = 64'd100;
    exp_q.push_back(pk(64'd100, 64'd7, 64'd0, 5'd7, 4'b0010, 0, 1, 0, 0, 0, 0));
    send(32'h8B020027, 64'h114);
    tb_if.wb_en = 1'b0;

    exp_q.push_back(pk(64'd7, 64'd100, 64'd0, 5'd10, 4'b0110, 0, 1, 0, 0, 0, 0));
    send(32'hCB01004A, 64'h118);
    exp_q.push_back(pk(64'd100, 64'd7, 64'd0, 5'd11, 4'b0000, 0, 1, 0, 0, 0, 0));
    send(32'h8A02002B, 64'h11C);
    exp_q.push_back(pk(64'd100, 64'd7, 64'd0, 5'd12, 4'b0001, 0, 1, 0, 0, 0, 0));
    send(32'hAA02002C, 64'h120);
    exp_q.push_back(pk(64'd7, 64'd0, 64'd1, 5'd13, 4'b0110, 1, 1, 0, 0, 0, 0));
    send(32'hD100044D, 64'h124);
    exp_q.push_back(pk(64'd0, 64'd0, 64'd0, 5'd0, 4'b0000, 0, 0, 0, 0, 0, 1));
    send(32'h00000000, 64'h128);
    tick();

    // LDUR X9,[X1,#-8] stalled by execute, STUR X2,[X1,#16] waiting behind it
    tb_if.ex_ready = 1'b0;
    ldur_exp = pk(64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 5'd9, 4'b0010, 1, 1, 1, 0, 0, 0);
    exp_q.push_back(ldur_exp);
    send(32'hF85F8029, 64'h200);
    tb_if.if_valid = 1'b1;
    tb_if.if_instr = 32'hF8010022;
    tb_if.if_pc    = 64'h204;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_id_ready", PW'(tb_if.id_ready), PW'(0));
      chk("stall_ex_valid", PW'(tb_if.ex_valid), PW'(1));
      chk("stall_hold", w_act, ldur_exp);
    end
    @(posedge clk);
    #1;
    tb_if.ex_ready = 1'b1;
    exp_q.push_back(pk(64'd100, 64'd7, 64'd16, 5'd2, 4'b0010, 1, 0, 0, 1, 0, 0));
    @(negedge clk);
    chk("unstall_id_ready", PW'(tb_if.id_ready), PW'(1));
    tick();
    tb_if.if_valid = 1'b0;
    @(negedge clk);
    chk("stur_loaded", PW'(tb_if.ex_valid), PW'(1));
    tick();

    // HALT, then fetch keeps offering for 10 cycles
    exp_q.push_back(pk(64'd0, 64'd0, 64'd0, 5'd0, 4'b0000, 0, 0, 0, 0, 1, 0));
    send(32'hFFE00000, 64'h300);
    tb_if.if_valid = 1'b1;
    tb_if.if_instr = 32'h8B020023;
    tb_if.if_pc    = 64'h304;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_id_ready", PW'(tb_if.id_ready), PW'(0));
    end
    @(posedge clk);
    #1;
    tb_if.if_valid = 1'b0;
    do_reset();
    @(negedge clk);
    chk("halt_reset_id_ready", PW'(tb_if.id_ready), PW'(1));
    chk("halt_reset_ex_valid", PW'(tb_if.ex_valid), PW'(0));
    chk("halt_reset_payload", w_act, '0);
    tick();

    // Reset while a redirect is pending
    send(32'h17FFFFFE, 64'h40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_cancels_pc_src", PW'(tb_if.pc_src), PW'(0));
    chk("reset_clears_target", PW'(tb_if.branch_address), PW'(0));
    tick();

    // Reset while ID/EX is stalled, then registers read back as 0
    wb(5'd1, 64'd33);
    tb_if.ex_ready = 1'b0;
    send(32'h8B020023, 64'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tb_if.ex_ready = 1'b1;
    @(negedge clk);
    chk("reset_drops_ex_valid", PW'(tb_if.ex_valid), PW'(0));
    chk("reset_drops_payload", w_act, '0);
    tick();
    exp_q.push_back(pk(64'd0, 64'd0, 64'd0, 5'd3, 4'b0010, 0, 1, 0, 0, 0, 0));
    send(32'h8B020023, 64'h0);
    tick();
    tick();

    chk("exp_q_drained", PW'(exp_q.size()), PW'(0));
    chk("br_q_drained", PW'(br_q.size()), PW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
- LEGv8 decode stage downstream of instruction fetch.
- Accepts {instruction, PC} from fetch through a valid/ready handshake.
- Holds the 32x64 register file, generates control signals and sign-extended immediates, and resolves B/CBZ/CBNZ locally.
- Returns pc_src and branch_address to fetch, and forwards non-branch instructions to execute through a registered ID/EX stage.

Parameters:
- XLEN, 64, register and PC width.
- NREGS, 32, architectural registers; index 31 is XZR.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  64  byte address of if_instr.
- id_ready  out  1  stage can accept this cycle.
- pc_src  out  1  redirect fetch; high for one cycle.
- branch_address  out  64  redirect target, valid while pc_src=1.
- ex_valid  out  1  ID/EX register holds an instruction.
- ex_ready  in  1  execute consumes the ID/EX contents.
- ex_rd1  out  64  Rn operand.
- ex_rd2  out  64  Rm (R-type) or Rt (STUR) operand.
- ex_imm  out  64  sign-/zero-extended immediate.
- ex_rd  out  5  destination register.
- ex_alu_op  out  4  0010 add, 0110 sub, 0000 and, 0001 orr.
- ex_alu_src  out  1  1 = use ex_imm as operand B.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  control signals.
- ex_halt  out  1  forwarded instruction is HALT.
- ex_illegal  out  1  unrecognised opcode; all other controls are 0.
- wb_en  in  1  writeback enable.
- wb_addr  in  5  writeback register index.
- wb_data  in  64  writeback value.

Behaviour:
- Reset (synchronous, active-high):
  - All registers X0..X30 = 0.
  - ex_valid=0, pc_src=0, branch_address=0, halted=0.
  - All ex_* payload outputs = 0.
- id_ready = !halted && (!ex_valid || ex_ready) || pc_src. A wrong-path slot is always drained.
- An instruction is accepted when if_valid && id_ready.
- Decode on bits [31:21]:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - ADDI 1001000100x, SUBI 1101000100x: imm = zero-extended [21:10].
  - LDUR 11111000010, STUR 11111000000: imm = sign-extended [20:12].
  - CBZ 10110100xxx, CBNZ 10110101xxx: imm = sign-extended [23:5] << 2.
  - B 000101xxxxx: imm = sign-extended [25:0] << 2.
  - HALT 11111111111.
  - Anything else is illegal.
- Register fields: Rd/Rt = [4:0], Rn = [9:5], Rm = [20:16].
- Register read is combinational with write bypass:
  - If wb_en && wb_addr==src && src!=31, the read returns wb_data.
  - Reads of index 31 always return 0.
- Register write occurs on clk when wb_en && wb_addr!=31. Writes to 31 are dropped.
- Accepted ALU/memory/HALT/illegal instruction: at the next edge, ex_valid=1 and the ID/EX fields are loaded.
- ID/EX register:
  - ex_valid clears on a cycle with ex_ready && no new accept.
  - While ex_valid && !ex_ready, all ex_* outputs hold stable.
- Accepted branch (B; CBZ with operand==0; CBNZ with operand!=0):
  - Nothing is forwarded; ex_valid is unchanged by this accept.
  - Next cycle: pc_src=1 and branch_address = if_pc + imm, modulo 2^64.
  - pc_src deasserts the following cycle.
- Not-taken CBZ/CBNZ is consumed with no effect.
- Flush: any instruction accepted while pc_src=1 is the wrong path.
  - It is discarded: no ID/EX load, no branch, no halt.
- HALT:
  - Forwarded with ex_halt=1.
  - Sets halted; id_ready=0 until reset. Register writes still proceed.
- Simultaneous writeback to, and read of, the same register in the accept cycle: the new wb_data is used.
- Reset mid-operation: reset wins over accept and writeback in the same cycle.
  - A pending pc_src is cancelled.
  - The ID/EX contents are dropped.

Test Plan:
- Reset, then wb X1=5 and X2=7; accept ADD X3,X1,X2 (0x8B020023) -> next cycle ex_valid=1, ex_rd1=5, ex_rd2=7, ex_rd=3, ex_alu_op=0010, ex_reg_write=1.
- Accept ADDI X4,XZR,#0xFFF in the same cycle as wb_en to X31 -> ex_rd1=0, ex_imm=0x0000000000000FFF, ex_alu_src=1; a later read of X31 returns 0.
- B with imm26 = -2 at PC=0x40 -> one-cycle pc_src=1 with branch_address=0x38; the instruction accepted during that cycle produces no ex_valid.
- CBZ X5 with X5=0 and imm19=4 at PC=0x10 -> branch_address=0x20. Repeat with X5=9 -> pc_src stays 0.
- Hold ex_ready=0 with LDUR in ID/EX -> id_ready=0 and ex_* stable for 3 cycles; raise ex_ready -> the next instruction loads in one cycle.
- Accept HALT (0xFFE00000) -> ex_halt=1, id_ready stays 0 while if_valid=1 for 10 cycles; assert reset -> id_ready=1, all outputs 0.
